// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   General-purpose integer register file for the RISC-V datapath:
//   2**ADDR_WIDTH entries of DATA_WIDTH bits, two combinational read ports and
//   one synchronous write port. Register x0 is hardwired to zero.
//
// Ports
//   read_reg_num1  in   ADDR_WIDTH  rs1 index
//   read_reg_num2  in   ADDR_WIDTH  rs2 index
//   write_reg      in   ADDR_WIDTH  rd index
//   write_data     in   DATA_WIDTH  data written to rd
//   read_data1     out  DATA_WIDTH  contents of rs1 (zero latency)
//   read_data2     out  DATA_WIDTH  contents of rs2 (zero latency)
//   regwrite       in   1           write enable, active-high
//   clock          in   1           writes land on the rising edge
//   reset          in   1           asynchronous, active-low; clears all entries
//
// There is no write-to-read forwarding: a read of the register being written
// returns the old value until the edge. Same-cycle bypass belongs to the
// pipeline.
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] read_reg_num1,
    input  logic [ADDR_WIDTH-1:0] read_reg_num2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic                  regwrite,
    input  logic                  clock,
    input  logic                  reset
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Writes to index 0 are dropped, so regs[0] only ever holds its reset
    // value and collapses to a constant in synthesis.
    logic write_en;
    assign write_en = regwrite && (write_reg != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // The explicit zero select keeps x0 reading zero independent of the array.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (read_reg_num1 != '0) begin
            read_data1 = regs[read_reg_num1];
        end
        if (read_reg_num2 != '0) begin
            read_data2 = regs[read_reg_num2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic [AW-1:0] read_reg_num1;
    logic [AW-1:0] read_reg_num2;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic          regwrite;
    logic          clock;
    logic          reset;

    int n_checks = 0;
    int n_errors = 0;

    reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .read_reg_num1 (read_reg_num1),
        .read_reg_num2 (read_reg_num2),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .regwrite      (regwrite),
        .clock         (clock),
        .reset         (reset)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clock);
        write_reg  = addr;
        write_data = data;
        regwrite   = 1'b1;
        @(posedge clock);
        #1;
        regwrite   = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        read_reg_num1 = a1;
        read_reg_num2 = a2;
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b0;
        regwrite      = 1'b0;
        write_reg     = '0;
        write_data    = '0;
        read_reg_num1 = '0;
        read_reg_num2 = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Preload nonzero contents, then assert reset between edges.
        wr(5'd1, 32'hA5A5_0001);
        wr(5'd31, 32'h5A5A_001F);
        rd(5'd1, 5'd31);
        check("preload_x1", read_data1, 32'hA5A5_0001);
        check("preload_x31", read_data2, 32'h5A5A_001F);

        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rst_imm_x1", read_data1, 32'h0);
        check("rst_imm_x31", read_data2, 32'h0);
        rd(5'd0, 5'd1);
        check("rst_x0", read_data1, 32'h0);
        check("rst_x1_p2", read_data2, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        rd(5'd31, 5'd1);
        check("rst_hold_x31", read_data1, 32'h0);

        // Basic write/read.
        wr(5'd1, 32'd30);
        rd(5'd1, 5'd2);
        check("wr_x1", read_data1, 32'd30);
        check("x2_zero", read_data2, 32'd0);

        // x0 protection.
        wr(5'd0, 32'd20);
        rd(5'd0, 5'd1);
        check("x0_zero", read_data1, 32'd0);
        check("x1_kept", read_data2, 32'd30);

        // Enable gating over several edges.
        @(negedge clock);
        regwrite   = 1'b0;
        write_reg  = 5'd5;
        write_data = 32'hDEAD_BEEF;
        repeat (3) @(posedge clock);
        #1;
        rd(5'd5, 5'd5);
        check("gate_x5", read_data1, 32'd0);

        // Read-during-write on both ports.
        wr(5'd7, 32'h11);
        @(negedge clock);
        read_reg_num1 = 5'd7;
        read_reg_num2 = 5'd7;
        write_reg     = 5'd7;
        write_data    = 32'h22;
        regwrite      = 1'b1;
        #1;
        check("rdw_pre_p1", read_data1, 32'h11);
        check("rdw_pre_p2", read_data2, 32'h11);
        @(posedge clock);
        #1;
        regwrite = 1'b0;
        check("rdw_post_p1", read_data1, 32'h22);
        check("rdw_post_p2", read_data2, 32'h22);

        // All-ones at the top index; neighbour untouched.
        wr(5'd31, 32'hFFFF_FFFF);
        rd(5'd31, 5'd30);
        check("x31_ones", read_data1, 32'hFFFF_FFFF);
        check("x30_zero", read_data2, 32'h0);

        // Async reset mid-operation while a write is pending.
        @(negedge clock);
        write_reg  = 5'd3;
        write_data = 32'h1234_5678;
        regwrite   = 1'b1;
        read_reg_num1 = 5'd31;
        read_reg_num2 = 5'd7;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_x31", read_data1, 32'h0);
        check("mid_rst_x7", read_data2, 32'h0);
        @(posedge clock);
        #1;
        rd(5'd3, 5'd1);
        check("rst_blocks_wr", read_data1, 32'h0);
        check("rst_x1", read_data2, 32'h0);

        // Release between edges; the next edge performs the pending write.
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rel_x3_pre", read_data1, 32'h0);
        @(posedge clock);
        #1;
        regwrite = 1'b0;
        check("rel_x3_post", read_data1, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
